// File: rtl/mem_stage_if.sv
// Handshake and bus bundles around the memory-access pipeline stage.
//
//   ex_mem_if   : EX -> MEM handshake and payload.
//                 master = EX stage, slave = MEM stage.
//   data_bus_if : SRAM-like data bus with req/addr_ok/data_ok.
//                 master = MEM stage, slave = memory.
//   mem_wb_if   : MEM -> WB handshake and payload.
//                 master = MEM stage, slave = WB stage.

interface ex_mem_if;
  logic        ex_to_mem_valid;
  logic        mem_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic [31:0] ex_alu_result;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_wdata;
  logic [4:0]  ex_rf_waddr;

  modport master (
    output ex_to_mem_valid, ex_pc, ex_inst, ex_alu_result, ex_mem_op,
           ex_mem_wdata, ex_rf_waddr,
    input  mem_ready
  );

  modport slave (
    input  ex_to_mem_valid, ex_pc, ex_inst, ex_alu_result, ex_mem_op,
           ex_mem_wdata, ex_rf_waddr,
    output mem_ready
  );
endinterface

interface data_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

interface mem_wb_if;
  logic        mem_to_wb_valid;
  logic        wb_ready;
  logic [31:0] mem_pc;
  logic [31:0] mem_inst;
  logic [31:0] mem_result;
  logic [4:0]  mem_rf_waddr;
  logic        mem_rf_we;
  logic        mem_ale;

  modport master (
    output mem_to_wb_valid, mem_pc, mem_inst, mem_result, mem_rf_waddr,
           mem_rf_we, mem_ale,
    input  wb_ready
  );

  modport slave (
    input  mem_to_wb_valid, mem_pc, mem_inst, mem_result, mem_rf_waddr,
           mem_rf_we, mem_ale,
    output wb_ready
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage.
//
// Latches the EX payload, runs at most one data-bus transaction for an
// aligned load or store, aligns/extends load data, builds store strobes
// and hands the result to WB over a valid/ready handshake. Misaligned
// halfword/word accesses skip the bus and retire with mem_ale set.
//
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset
//   ex_bus   : EX -> MEM handshake and payload (slave side)
//   data_bus : data bus req/addr_ok/data_ok (master side)
//   wb_bus   : MEM -> WB handshake and payload (master side)

module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_mem_if.slave     ex_bus,
  data_bus_if.master  data_bus,
  mem_wb_if.master    wb_bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_valid;
  logic [31:0]       r_pc;
  logic [31:0]       r_inst;
  logic [31:0]       r_addr;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [4:0]        r_waddr;

  logic              w_readyGo;
  logic              w_memReady;
  logic              w_accept;
  logic              w_exMemGo;
  logic              w_ale;
  logic [DATA_W-1:0] w_loadSrc;
  logic [DATA_W-1:0] w_shifted;
  logic [31:0]       w_loadData;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_wdata;

  function automatic logic isLoad(input logic [3:0] op);
    return op inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
  endfunction

  function automatic logic isStore(input logic [3:0] op);
    return op inside {4'b1001, 4'b1010, 4'b1011};
  endfunction

  function automatic logic isMisaligned(input logic [3:0] op,
                                        input logic [1:0] lowAddr);
    logic half;
    logic word;
    half = op inside {4'b0010, 4'b0101, 4'b1010};
    word = op inside {4'b0011, 4'b1011};
    return (half & lowAddr[0]) | (word & (lowAddr != 2'b00));
  endfunction

  // Only aligned memory ops go to the bus; everything else retires from IDLE.
  assign w_exMemGo = (isLoad(ex_bus.ex_mem_op) | isStore(ex_bus.ex_mem_op)) &
                     ~isMisaligned(ex_bus.ex_mem_op, ex_bus.ex_alu_result[1:0]);

  assign w_ale      = isMisaligned(r_op, r_addr[1:0]);
  assign w_memReady = ~r_valid | (w_readyGo & wb_bus.wb_ready);
  assign w_accept   = ex_bus.ex_to_mem_valid & w_memReady;

  // A retire with a new acceptance picks the next state from the new op,
  // which is what lets back-to-back ops run without a bubble.
  always_comb begin
    w_readyGo   = 1'b0;
    w_nextState = r_state;
    case (r_state)
      IDLE:    w_readyGo = 1'b1;
      REQ:     w_readyGo = 1'b0;
      WAIT:    w_readyGo = data_bus.data_data_ok;
      DONE:    w_readyGo = 1'b1;
      default: w_readyGo = 1'b0;
    endcase

    if (w_accept) begin
      w_nextState = w_exMemGo ? REQ : IDLE;
    end else if (w_memReady) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        REQ:     if (data_bus.data_addr_ok) w_nextState = WAIT;
        WAIT:    if (data_bus.data_data_ok) w_nextState = DONE;
        default: w_nextState = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
      r_addr  <= '0;
      r_op    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_waddr <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_memReady) begin
        r_valid <= ex_bus.ex_to_mem_valid;
      end
      if (w_accept) begin
        r_pc    <= ex_bus.ex_pc;
        r_inst  <= ex_bus.ex_inst;
        r_addr  <= ex_bus.ex_alu_result;
        r_op    <= ex_bus.ex_mem_op;
        r_wdata <= ex_bus.ex_mem_wdata;
        r_waddr <= ex_bus.ex_rf_waddr;
      end
      // Keep the response in case WB stalls and we sit in DONE.
      if ((r_state == WAIT) && data_bus.data_data_ok) begin
        r_rdata <= data_bus.data_rdata;
      end
    end
  end

  // Live bus data in the data_ok cycle, held copy once parked in DONE.
  always_comb begin
    w_loadSrc  = (r_state == DONE) ? r_rdata : data_bus.data_rdata;
    w_shifted  = w_loadSrc >> {r_addr[1:0], 3'b000};
    w_loadData = w_shifted;
    case (r_op)
      4'b0001: w_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
      4'b0100: w_loadData = {24'h000000, w_shifted[7:0]};
      4'b0010: w_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
      4'b0101: w_loadData = {16'h0000, w_shifted[15:0]};
      default: w_loadData = w_shifted;
    endcase
  end

  // Store data is replicated across lanes so the strobes pick the right bytes.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = r_wdata;
    case (r_op)
      4'b1001: begin
        w_wstrb = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      4'b1010: begin
        w_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      4'b1011: begin
        w_wstrb = 4'b1111;
        w_wdata = r_wdata;
      end
      default: begin
        w_wstrb = 4'b0000;
        w_wdata = r_wdata;
      end
    endcase
  end

  assign ex_bus.mem_ready = w_memReady;

  assign data_bus.data_req   = (r_state == REQ);
  assign data_bus.data_wr    = isStore(r_op);
  assign data_bus.data_wstrb = w_wstrb;
  assign data_bus.data_addr  = r_addr[ADDR_W-1:0];
  assign data_bus.data_wdata = w_wdata;

  assign wb_bus.mem_to_wb_valid = r_valid & w_readyGo;
  assign wb_bus.mem_pc          = r_pc;
  assign wb_bus.mem_inst        = r_inst;
  assign wb_bus.mem_rf_waddr    = r_waddr;
  assign wb_bus.mem_result      = (isLoad(r_op) & ~w_ale) ? w_loadData : r_addr;
  assign wb_bus.mem_rf_we       = (r_waddr != 5'd0) & ~isStore(r_op) & ~w_ale;
  assign wb_bus.mem_ale         = w_ale;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. It is the consumer of the EX-stage valid/ready handshake (ex_to_mem_valid in, mem_ready out).
- Latches the EX payload and, for loads and stores, runs one SRAM-like data-bus transaction (req/addr_ok/data_ok).
- Aligns and extends load data, builds store byte strobes.
- Hands the result to WB through a second valid/ready handshake.

Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, data width (fixed at 32; strobe logic assumes 4 bytes)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_to_mem_valid  in  1  EX has a valid instruction
- mem_ready  out  1  stage can accept this cycle (allowin to EX)
- ex_pc  in  32  instruction PC
- ex_inst  in  32  instruction word
- ex_alu_result  in  32  ALU result; this is the address for memory ops
- ex_mem_op  in  4  memory op code (see Behaviour)
- ex_mem_wdata  in  32  store source data
- ex_rf_waddr  in  5  destination register
- data_req  out  1  data-bus request
- data_wr  out  1  1 = store
- data_wstrb  out  4  byte enables for stores (0 for loads)
- data_addr  out  32  request address
- data_wdata  out  32  store data, replicated per size
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response/write-ack returned
- data_rdata  in  32  load data, valid with data_data_ok
- mem_to_wb_valid  out  1  WB payload valid
- wb_ready  in  1  WB can accept
- mem_pc  out  32  PC passed to WB
- mem_inst  out  32  instruction word passed to WB
- mem_result  out  32  writeback value
- mem_rf_waddr  out  5  destination register
- mem_rf_we  out  1  register write enable
- mem_ale  out  1  misaligned-address flag

Behaviour:
- Op codes:
  - 0000 none
  - 0001 LD.B, 0010 LD.H, 0011 LD.W, 0100 LD.BU, 0101 LD.HU
  - 1001 ST.B, 1010 ST.H, 1011 ST.W
  - any other code is treated as none.
- Handshake: mem_ready = ~valid_r | (ready_go & wb_ready); mem_to_wb_valid = valid_r & ready_go.
  - Accept when ex_to_mem_valid & mem_ready: valid_r <= 1 and the payload is latched. If mem_ready is 1 with no incoming valid, valid_r <= 0.
- Misaligned access: H with addr[0]≠0, or W with addr[1:0]≠0.
  - No bus request is issued; ready_go = 1 immediately.
  - mem_ale = 1, mem_rf_we = 0, mem_result = latched address.
- FSM states: IDLE, REQ, WAIT, DONE.
  - Acceptance of an aligned mem op → REQ (next cycle). Acceptance of anything else → IDLE.
  - REQ: data_req = 1. addr, wr, wstrb and wdata are driven from latched regs and held stable until data_addr_ok. REQ & data_addr_ok → WAIT.
  - WAIT: data_req = 0. On data_data_ok, data_rdata is captured into rdata_r.
    - If wb_ready, the stage retires that same cycle (pass-through; ready_go = 1) and the next state is REQ/IDLE per any newly accepted op.
    - Otherwise → DONE.
  - DONE: ready_go = 1; stays in DONE until a transfer to WB, then → IDLE or REQ per the newly accepted op.
  - Non-mem op: ready_go = 1 in IDLE.
- Minimum latencies:
  - Load/store: accept cycle + 1 REQ cycle + ≥1 WAIT cycle.
  - Non-mem: visible to WB the cycle after acceptance.
- Store formatting:
  - ST.B: wstrb = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - ST.H: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - ST.W: wstrb = 1111, wdata unchanged.
  - data_addr = latched address, unmodified.
- Load formatting: shifted = rdata >> (8*addr[1:0]).
  - LD.B sign-extends [7:0]; LD.BU zero-extends [7:0].
  - LD.H sign-extends [15:0]; LD.HU zero-extends [15:0].
  - LD.W takes all 32 bits.
  - The source is data_rdata in the data_ok cycle, rdata_r in DONE.
- mem_result: load data for loads, latched ex_alu_result otherwise.
- mem_rf_we = (rf_waddr≠0) & ~store & ~ale.
- mem_pc, mem_inst and mem_rf_waddr come from the latched regs.
- At most one outstanding transaction. data_data_ok outside WAIT is ignored.
- Reset:
  - valid_r = 0, state = IDLE, all payload regs and rdata_r = 0.
  - Outputs: data_req = 0, mem_to_wb_valid = 0, mem_ready = 1, data_wstrb = 0, mem_ale = 0, mem_rf_we = 0.
  - Reset mid-transaction abandons it; the memory side is reset together with this stage.

Test Plan:
- ADD result 0x1234 to r5, wb_ready = 1 → mem_to_wb_valid the next cycle, mem_result = 0x1234, mem_rf_we = 1, no data_req.
- LD.B addr 0x103, rdata 0x80FF_0000 → wstrb = 0, data_addr = 0x103, mem_result = 0xFFFF_FF80. With LD.BU instead → mem_result = 0x80.
- ST.H addr 0x202, wdata 0xABCD → data_wr = 1, wstrb = 1100, data_wdata = 0xABCD_ABCD, mem_rf_we = 0.
- addr_ok held low 3 cycles, then data_ok 2 cycles later with wb_ready = 0 for 2 more cycles → request signals stable, state DONE, mem_ready = 0 throughout, and the single WB transfer carries the correct data.
- LD.W addr 0x101 → no data_req, mem_ale = 1, mem_rf_we = 0, completes the next cycle.
- Back-to-back LD.W, LD.W with zero-wait memory and wb_ready = 1 → second accepted in the cycle the first retires, no bubble beyond protocol latency. Assert rst during WAIT → data_req = 0, mem_to_wb_valid = 0, mem_ready = 1 the next cycle.
